gty_lane_axis_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that shares the single AXI4-Stream S2MM path into the AXI DMA / DDR4 between N GTY lane streams.
- Each input is one lane's RX-to-AXIS bridge output.
- Once a lane is granted it holds the output until its TLAST beat is accepted, so packets never interleave.
- The source lane index is carried on TDEST so software can demultiplex buffers.

---
 rtl/gty_lane_axis_arbiter.sv | 106 ++++++++++
 tb/tb_gty_lane_axis_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gty_lane_axis_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_PORTS lane AXI4-Stream inputs
// onto one S2MM stream; a granted lane keeps the output until its TLAST beat is accepted.
module gty_lane_axis_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic                              arb_enable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]              s_axis_tlast,
  output logic [NUM_PORTS-1:0]              s_axis_tready,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  output logic [ID_WIDTH-1:0]               m_axis_tdest,
  input  logic                              m_axis_tready,
  output logic                              busy,
  output logic [ID_WIDTH-1:0]               grant_id,
  output logic [31:0]                       pkt_count
);

  localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

  typedef enum logic {IDLE, XFER} state_t;

  state_t              state, state_next;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant_next;
  logic                grant_found;
  logic                beat_done;

  assign beat_done    = m_axis_tvalid && m_axis_tready;
  assign busy         = (state == XFER);
  assign m_axis_tdest = grant_id;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      rr_ptr    <= ID_WIDTH'(NUM_PORTS - 1);
      grant_id  <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == XFER)
        grant_id <= grant_next;
      if (beat_done && m_axis_tlast) begin
        rr_ptr    <= grant_id;
        pkt_count <= pkt_count + 32'd1;
      end
    end
  end

  // Rotating priority without modulo: the lowest requester above rr_ptr wins,
  // otherwise the lowest requester at or below it. Lanes >= NUM_PORTS never exist here.
  always_comb begin
    grant_next  = '0;
    grant_found = 1'b0;
    for (int unsigned i = NUM_PORTS; i > 0; i--) begin
      if (s_axis_tvalid[i-1] && ID_WIDTH'(i-1) <= rr_ptr) begin
        grant_found = 1'b1;
        grant_next  = ID_WIDTH'(i-1);
      end
    end
    for (int unsigned i = NUM_PORTS; i > 0; i--) begin
      if (s_axis_tvalid[i-1] && ID_WIDTH'(i-1) > rr_ptr) begin
        grant_found = 1'b1;
        grant_next  = ID_WIDTH'(i-1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_enable && grant_found) state_next = XFER;
      XFER:    if (beat_done && m_axis_tlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // m_axis_tvalid depends only on state and lane valid, never on m_axis_tready.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == XFER) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (grant_id == ID_WIDTH'(i)) begin
          m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tlast     = s_axis_tlast[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

endmodule

// File: tb/tb_gty_lane_axis_arbiter.sv
// Scoreboard bench for gty_lane_axis_arbiter: lane sources replay directed packets,
// expected output beats are queued at issue time and popped by an independent monitor.
module tb_gty_lane_axis_arbiter;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  dest;
  } beat_t;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         arb_enable = 1'b1;
  logic [255:0] s_axis_tdata = '0;
  logic [31:0]  s_axis_tkeep = '0;
  logic [3:0]   s_axis_tvalid = '0;
  logic [3:0]   s_axis_tlast = '0;
  logic [3:0]   s_axis_tready;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic [1:0]   m_axis_tdest;
  logic         m_axis_tready = 1'b1;
  logic         busy;
  logic [1:0]   grant_id;
  logic [31:0]  pkt_count;

  gty_lane_axis_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(64), .ID_WIDTH(2)) dut (
    .aclk(aclk), .aresetn(aresetn), .arb_enable(arb_enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest), .m_axis_tready(m_axis_tready),
    .busy(busy), .grant_id(grant_id), .pkt_count(pkt_count)
  );

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  beat_t exp_q[$];
  int    acc_cyc[$];
  int    acc_cnt = 0;
  beat_t mem[4][64];
  int    wr[4];
  int    rd[4];
  logic  [3:0] fire;
  logic  [3:0] allow_mask = 4'hF;
  int    rdy_viol = 0;
  logic  chk_follow = 1'b0;
  int    follow_viol = 0;
  logic  idle_watch = 1'b0;
  int    idle_viol = 0;
  logic  tog = 1'b0;

  initial forever #5 aclk = ~aclk;
  initial forever begin @(posedge aclk); cyc++; end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic beat_t make_beat(input int lane, input int pkt, input int b, input int n);
    beat_t x;
    x.data = {16'hC0DE, 8'(lane), 8'(pkt), 24'h0, 8'(b)};
    x.last = (b == n - 1);
    x.keep = x.last ? (8'h81 | 8'(lane << 1)) : 8'hFF;
    x.dest = 2'(lane);
    return x;
  endfunction

  task automatic present();
    for (int i = 0; i < 4; i++) begin
      if (rd[i] < wr[i]) begin
        s_axis_tdata[i*64 +: 64] = mem[i][rd[i]].data;
        s_axis_tkeep[i*8 +: 8]   = mem[i][rd[i]].keep;
        s_axis_tlast[i]          = mem[i][rd[i]].last;
        s_axis_tvalid[i]         = 1'b1;
      end else begin
        s_axis_tdata[i*64 +: 64] = '0;
        s_axis_tkeep[i*8 +: 8]   = '0;
        s_axis_tlast[i]          = 1'b0;
        s_axis_tvalid[i]         = 1'b0;
      end
    end
  endtask

  task automatic load_pkt(input int lane, input int pkt, input int n);
    for (int b = 0; b < n; b++) begin
      mem[lane][wr[lane]] = make_beat(lane, pkt, b, n);
      wr[lane]++;
    end
    present();
  endtask

  task automatic expect_beats(input int lane, input int pkt, input int n, input int from, input int upto);
    for (int b = from; b <= upto; b++) exp_q.push_back(make_beat(lane, pkt, b, n));
  endtask

  task automatic wait_beats(input int n, input string tag);
    int k = 0;
    do begin
      @(posedge aclk); #2;
      k++;
    end while (acc_cnt < n && k < 200);
    checks++;
    if (acc_cnt < n) begin
      errors++;
      $display("FAIL %s timeout: beats=%0d required=%0d", tag, acc_cnt, n);
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    m_axis_tready = 1'b1;
    arb_enable = 1'b1;
    tog = 1'b0;
    repeat (2) @(posedge aclk);
    #2;
    for (int i = 0; i < 4; i++) begin wr[i] = 0; rd[i] = 0; end
    present();
    acc_cnt = 0;
    acc_cyc.delete();
    rdy_viol = 0;
    allow_mask = 4'hF;
    aresetn = 1'b1;
  endtask

  // Lane sources: pop a beat after every accepted handshake.
  initial forever begin
    @(negedge aclk);
    fire = s_axis_tvalid & s_axis_tready & {4{aresetn}};
    @(posedge aclk);
    #1;
    for (int i = 0; i < 4; i++) if (fire[i]) rd[i]++;
    if (tog) m_axis_tready = ~m_axis_tready;
    present();
  end

  // Monitor: compares every accepted output beat against the scoreboard head.
  initial forever begin
    beat_t e;
    @(negedge aclk);
    if (aresetn) begin
      if ((s_axis_tready & ~allow_mask) != 0 || $countones(s_axis_tready) > 1) rdy_viol++;
      if (chk_follow && busy && (s_axis_tready[0] !== m_axis_tready)) follow_viol++;
      if (idle_watch && m_axis_tvalid) idle_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
        acc_cnt++;
        acc_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest}, '1);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tdest}, e);
        end
      end
    end
  end

  initial begin
    int en_cyc;
    for (int i = 0; i < 4; i++) begin wr[i] = 0; rd[i] = 0; end
    do_reset();

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);

    // 1: four lanes, one 4-beat packet each -> order 0,1,2,3
    for (int l = 0; l < 4; l++) begin load_pkt(l, 1, 4); expect_beats(l, 1, 4, 0, 3); end
    wait_beats(16, "t1");
    chk("t1_pkt_count", pkt_count, 4);
    chk("t1_busy", busy, 0);
    chk("t1_drain", exp_q.size(), 0);
    chk("t1_rdy_onehot", rdy_viol, 0);

    // 2: lane 2 only, three 1-beat packets -> one every 2nd cycle
    do_reset();
    allow_mask = 4'b0100;
    for (int p = 0; p < 3; p++) begin load_pkt(2, p, 1); expect_beats(2, p, 1, 0, 0); end
    wait_beats(3, "t2");
    chk("t2_gap1", acc_cyc[1] - acc_cyc[0], 2);
    chk("t2_gap2", acc_cyc[2] - acc_cyc[1], 2);
    chk("t2_pkt_count", pkt_count, 3);
    chk("t2_other_tready", rdy_viol, 0);
    chk("t2_drain", exp_q.size(), 0);

    // 3: lane 1 mid-packet while lanes 0 and 3 arrive -> 1, 3, 0
    do_reset();
    load_pkt(1, 7, 8); expect_beats(1, 7, 8, 0, 7);
    wait_beats(2, "t3a");
    load_pkt(0, 8, 2); load_pkt(3, 9, 3);
    expect_beats(3, 9, 3, 0, 2); expect_beats(0, 8, 2, 0, 1);
    wait_beats(13, "t3b");
    chk("t3_pkt_count", pkt_count, 3);
    chk("t3_drain", exp_q.size(), 0);

    // 4: m_axis_tready toggling during a 6-beat lane-0 packet
    do_reset();
    follow_viol = 0;
    chk_follow = 1'b1;
    tog = 1'b1;
    load_pkt(0, 4, 6); expect_beats(0, 4, 6, 0, 5);
    wait_beats(6, "t4");
    repeat (4) @(posedge aclk);
    #2;
    chk_follow = 1'b0;
    tog = 1'b0;
    m_axis_tready = 1'b1;
    chk("t4_transfers", acc_cnt, 6);
    chk("t4_tready_follow", follow_viol, 0);
    chk("t4_pkt_count", pkt_count, 1);
    chk("t4_drain", exp_q.size(), 0);

    // 5: arb_enable dropped at beat 2 of lane 0; others pending
    do_reset();
    load_pkt(0, 5, 5); load_pkt(1, 5, 1); load_pkt(2, 5, 1);
    expect_beats(0, 5, 5, 0, 4); expect_beats(1, 5, 1, 0, 0); expect_beats(2, 5, 1, 0, 0);
    wait_beats(2, "t5a");
    arb_enable = 1'b0;
    wait_beats(5, "t5b");
    idle_viol = 0;
    idle_watch = 1'b1;
    repeat (8) @(posedge aclk);
    #2;
    idle_watch = 1'b0;
    chk("t5_hold_transfers", acc_cnt, 5);
    chk("t5_hold_tvalid", idle_viol, 0);
    chk("t5_busy_hold", busy, 0);
    arb_enable = 1'b1;
    en_cyc = cyc;
    wait_beats(7, "t5c");
    chk("t5_regrant_latency", acc_cyc[5] - en_cyc, 1);
    chk("t5_pkt_count", pkt_count, 3);
    chk("t5_drain", exp_q.size(), 0);

    // 6: reset at beat 3 of a lane-1 packet (no do_reset: pkt_count is 3 here)
    acc_cnt = 0;
    acc_cyc.delete();
    load_pkt(1, 6, 6); expect_beats(1, 6, 6, 0, 2);
    wait_beats(3, "t6a");
    aresetn = 1'b0;
    load_pkt(0, 6, 2);
    @(posedge aclk);
    #2;
    chk("t6_rst_tready", s_axis_tready, 0);
    chk("t6_rst_pkt_count", pkt_count, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tvalid", m_axis_tvalid, 0);
    expect_beats(0, 6, 2, 0, 1); expect_beats(1, 6, 6, 3, 5);
    aresetn = 1'b1;
    wait_beats(8, "t6b");
    chk("t6_pkt_count", pkt_count, 2);
    chk("t6_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
